// File: rtl/accum_result_collector_if.sv
// Handshake and write-snoop bundle between the block-accumulate controller,
// the result collector and its downstream consumer.
interface accum_result_collector_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  WriteEnable;
    logic [4:0]            Address;
    logic [DATA_WIDTH-1:0] DataIn;
    logic                  Ready;
    logic                  ClearFlags;
    logic                  OutReady;
    logic                  OutValid;
    logic [DATA_WIDTH-1:0] OutData;
    logic [1:0]            OutIndex;
    logic                  OutLast;
    logic [DATA_WIDTH+1:0] Total;
    logic                  Overrun;
    logic                  Incomplete;
    logic                  AddrError;

    modport master (
        output WriteEnable, Address, DataIn, Ready, ClearFlags, OutReady,
        input  OutValid, OutData, OutIndex, OutLast, Total,
               Overrun, Incomplete, AddrError
    );

    modport slave (
        input  WriteEnable, Address, DataIn, Ready, ClearFlags, OutReady,
        output OutValid, OutData, OutIndex, OutLast, Total,
               Overrun, Incomplete, AddrError
    );
endinterface

// File: rtl/accum_result_collector.sv
// Snoops block-sum write-backs into a capture bank and, on Ready, streams the
// four sums out over valid/ready together with their grand total.
module accum_result_collector #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    accum_result_collector_if.slave  bus
);
    typedef enum logic {IDLE, STREAM} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] cap_bank [4];
    logic [DATA_WIDTH-1:0] out_bank [4];
    logic [3:0]            cap_vld;
    logic [1:0]            idx;
    logic [DATA_WIDTH+1:0] total;
    logic                  overrun, incomplete, addr_error;

    logic                  wr_hit, wr_bad, load, short_set, late_ready, xfer;
    logic [3:0]            wr_onehot;

    function automatic logic [DATA_WIDTH+1:0] sum4(
        input logic [DATA_WIDTH-1:0] a, b, c, d
    );
        return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    endfunction

    assign wr_hit     = bus.WriteEnable && (bus.Address[2:0] == 3'b111);
    assign wr_bad     = bus.WriteEnable && (bus.Address[2:0] != 3'b111);
    assign wr_onehot  = wr_hit ? (4'b0001 << bus.Address[4:3]) : 4'b0000;
    assign load       = bus.Ready && (state_q == IDLE) && (&cap_vld);
    assign short_set  = bus.Ready && (state_q == IDLE) && !(&cap_vld);
    assign late_ready = bus.Ready && (state_q == STREAM);
    assign xfer       = (state_q == STREAM) && bus.OutReady;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = STREAM;
            STREAM:  if (xfer && idx == 2'd3) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.OutValid = 1'b0;
        bus.OutData  = '0;
        bus.OutIndex = 2'd0;
        bus.OutLast  = 1'b0;
        if (state_q == STREAM) begin
            bus.OutValid = 1'b1;
            bus.OutData  = out_bank[idx];
            bus.OutIndex = idx;
            bus.OutLast  = (idx == 2'd3);
        end
    end

    assign bus.Total      = total;
    assign bus.Overrun    = overrun;
    assign bus.Incomplete = incomplete;
    assign bus.AddrError  = addr_error;

    // Ready always evaluates the pre-edge bank; a same-cycle write lands in the cleared bank.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                cap_bank[i] <= '0;
                out_bank[i] <= '0;
            end
            cap_vld    <= 4'b0000;
            idx        <= 2'd0;
            total      <= '0;
            overrun    <= 1'b0;
            incomplete <= 1'b0;
            addr_error <= 1'b0;
        end else begin
            if (wr_hit) cap_bank[bus.Address[4:3]] <= bus.DataIn;
            cap_vld <= (bus.Ready ? 4'b0000 : cap_vld) | wr_onehot;

            if (load) begin
                for (int i = 0; i < 4; i++) out_bank[i] <= cap_bank[i];
                total <= sum4(cap_bank[0], cap_bank[1], cap_bank[2], cap_bank[3]);
                idx   <= 2'd0;
            end else if (xfer && idx != 2'd3) begin
                idx <= idx + 2'd1;
            end

            overrun    <= late_ready | (overrun    & ~bus.ClearFlags);
            incomplete <= short_set  | (incomplete & ~bus.ClearFlags);
            addr_error <= wr_bad     | (addr_error & ~bus.ClearFlags);
        end
    end
endmodule

// File: tb/tb_accum_result_collector.sv
// Directed, table-driven bench for accum_result_collector with hand-written
// reset sequences.
module tb_accum_result_collector;
    logic Clock;
    logic Reset;

    accum_result_collector_if #(.DATA_WIDTH(8)) bus ();

    accum_result_collector #(.DATA_WIDTH(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic       we;
        logic [4:0] addr;
        logic [7:0] din;
        logic       rdy;
        logic       clr;
        logic       ordy;
        logic       e_vld;
        logic [7:0] e_dat;
        logic [1:0] e_idx;
        logic       e_last;
        logic [9:0] e_tot;
        logic [2:0] e_flg;   // {Overrun, Incomplete, AddrError}
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input logic we, input logic [4:0] addr, input logic [7:0] din,
                       input logic rdy, input logic clr, input logic ordy,
                       input logic ev, input logic [7:0] ed, input logic [1:0] ei,
                       input logic el, input logic [9:0] et, input logic [2:0] ef);
        vec_t v;
        v = '{we, addr, din, rdy, clr, ordy, ev, ed, ei, el, et, ef};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] addr, input logic [7:0] din,
                         input logic rdy, input logic clr, input logic ordy);
        bus.WriteEnable = we;
        bus.Address     = addr;
        bus.DataIn      = din;
        bus.Ready       = rdy;
        bus.ClearFlags  = clr;
        bus.OutReady    = ordy;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_outs(input string tag, input int row, input logic ev,
                            input logic [7:0] ed, input logic [1:0] ei, input logic el,
                            input logic [9:0] et, input logic [2:0] ef);
        chk({tag, "_vld"}, row, 32'(bus.OutValid), 32'(ev));
        if (ev) begin
            chk({tag, "_dat"},  row, 32'(bus.OutData),  32'(ed));
            chk({tag, "_idx"},  row, 32'(bus.OutIndex), 32'(ei));
            chk({tag, "_last"}, row, 32'(bus.OutLast),  32'(el));
        end
        chk({tag, "_tot"}, row, 32'(bus.Total), 32'(et));
        chk({tag, "_flg"}, row, 32'({bus.Overrun, bus.Incomplete, bus.AddrError}), 32'(ef));
    endtask

    initial begin
        Reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        // Full set 10/20/30/40, streamed with OutReady held high
        add(1,  7, 8'h10, 0,0,0, 0, 0, 0,0, 10'h000, 0);
        add(1, 15, 8'h20, 0,0,0, 0, 0, 0,0, 10'h000, 0);
        add(1, 23, 8'h30, 0,0,0, 0, 0, 0,0, 10'h000, 0);
        add(1, 31, 8'h40, 0,0,0, 0, 0, 0,0, 10'h000, 0);
        add(0,  0, 8'h00, 1,0,1, 1, 8'h10, 0,0, 10'h0A0, 0);
        add(0,  0, 8'h00, 0,0,1, 1, 8'h20, 1,0, 10'h0A0, 0);
        add(0,  0, 8'h00, 0,0,1, 1, 8'h30, 2,0, 10'h0A0, 0);
        add(0,  0, 8'h00, 0,0,1, 1, 8'h40, 3,1, 10'h0A0, 0);
        add(0,  0, 8'h00, 0,0,1, 0, 0, 0,0, 10'h0A0, 0);
        // All 0xFF, OutReady pattern 1,0,0,1,1,0,1
        add(1,  7, 8'hFF, 0,0,0, 0, 0, 0,0, 10'h0A0, 0);
        add(1, 15, 8'hFF, 0,0,0, 0, 0, 0,0, 10'h0A0, 0);
        add(1, 23, 8'hFF, 0,0,0, 0, 0, 0,0, 10'h0A0, 0);
        add(1, 31, 8'hFF, 0,0,0, 0, 0, 0,0, 10'h0A0, 0);
        add(0,  0, 8'h00, 1,0,0, 1, 8'hFF, 0,0, 10'h3FC, 0);
        add(0,  0, 8'h00, 0,0,1, 1, 8'hFF, 1,0, 10'h3FC, 0);
        add(0,  0, 8'h00, 0,0,0, 1, 8'hFF, 1,0, 10'h3FC, 0);
        add(0,  0, 8'h00, 0,0,0, 1, 8'hFF, 1,0, 10'h3FC, 0);
        add(0,  0, 8'h00, 0,0,1, 1, 8'hFF, 2,0, 10'h3FC, 0);
        add(0,  0, 8'h00, 0,0,1, 1, 8'hFF, 3,1, 10'h3FC, 0);
        add(0,  0, 8'h00, 0,0,0, 1, 8'hFF, 3,1, 10'h3FC, 0);
        add(0,  0, 8'h00, 0,0,1, 0, 0, 0,0, 10'h3FC, 0);
        // Three sums only -> Incomplete, then cleared
        add(1,  7, 8'h01, 0,0,0, 0, 0, 0,0, 10'h3FC, 0);
        add(1, 15, 8'h02, 0,0,0, 0, 0, 0,0, 10'h3FC, 0);
        add(1, 23, 8'h03, 0,0,0, 0, 0, 0,0, 10'h3FC, 0);
        add(0,  0, 8'h00, 1,0,1, 0, 0, 0,0, 10'h3FC, 3'b010);
        add(0,  0, 8'h00, 0,1,0, 0, 0, 0,0, 10'h3FC, 0);
        // Overrun: second set arrives while the first is stalled
        add(1,  7, 8'h01, 0,0,0, 0, 0, 0,0, 10'h3FC, 0);
        add(1, 15, 8'h02, 0,0,0, 0, 0, 0,0, 10'h3FC, 0);
        add(1, 23, 8'h03, 0,0,0, 0, 0, 0,0, 10'h3FC, 0);
        add(1, 31, 8'h04, 0,0,0, 0, 0, 0,0, 10'h3FC, 0);
        add(0,  0, 8'h00, 1,0,0, 1, 8'h01, 0,0, 10'h00A, 0);
        add(1,  7, 8'h05, 0,0,0, 1, 8'h01, 0,0, 10'h00A, 0);
        add(1, 15, 8'h06, 0,0,0, 1, 8'h01, 0,0, 10'h00A, 0);
        add(1, 23, 8'h07, 0,0,0, 1, 8'h01, 0,0, 10'h00A, 0);
        add(1, 31, 8'h08, 0,0,0, 1, 8'h01, 0,0, 10'h00A, 0);
        add(0,  0, 8'h00, 1,0,0, 1, 8'h01, 0,0, 10'h00A, 3'b100);
        add(0,  0, 8'h00, 0,0,1, 1, 8'h02, 1,0, 10'h00A, 3'b100);
        add(0,  0, 8'h00, 0,0,1, 1, 8'h03, 2,0, 10'h00A, 3'b100);
        add(0,  0, 8'h00, 0,0,1, 1, 8'h04, 3,1, 10'h00A, 3'b100);
        add(0,  0, 8'h00, 0,0,1, 0, 0, 0,0, 10'h00A, 3'b100);
        add(0,  0, 8'h00, 1,0,0, 0, 0, 0,0, 10'h00A, 3'b110);
        add(0,  0, 8'h00, 0,1,0, 0, 0, 0,0, 10'h00A, 0);
        // Bad address leaves the bank alone; write coincident with Ready is held
        add(1,  3, 8'h55, 0,0,0, 0, 0, 0,0, 10'h00A, 3'b001);
        add(0,  0, 8'h00, 0,1,0, 0, 0, 0,0, 10'h00A, 0);
        add(1, 15, 8'h22, 0,0,0, 0, 0, 0,0, 10'h00A, 0);
        add(1, 23, 8'h33, 0,0,0, 0, 0, 0,0, 10'h00A, 0);
        add(1, 31, 8'h44, 0,0,0, 0, 0, 0,0, 10'h00A, 0);
        add(1,  7, 8'h11, 1,0,0, 0, 0, 0,0, 10'h00A, 3'b010);
        add(1, 15, 8'h22, 0,1,0, 0, 0, 0,0, 10'h00A, 0);
        add(1, 23, 8'h33, 0,0,0, 0, 0, 0,0, 10'h00A, 0);
        add(1, 31, 8'h44, 0,0,0, 0, 0, 0,0, 10'h00A, 0);
        add(0,  0, 8'h00, 1,0,1, 1, 8'h11, 0,0, 10'h0AA, 0);
        add(0,  0, 8'h00, 0,0,1, 1, 8'h22, 1,0, 10'h0AA, 0);
        add(0,  0, 8'h00, 0,0,1, 1, 8'h33, 2,0, 10'h0AA, 0);
        add(0,  0, 8'h00, 0,0,1, 1, 8'h44, 3,1, 10'h0AA, 0);
        add(0,  0, 8'h00, 0,0,1, 0, 0, 0,0, 10'h0AA, 0);
        // Set and clear in the same cycle: set wins
        add(1,  0, 8'h00, 0,1,0, 0, 0, 0,0, 10'h0AA, 3'b001);
        add(0,  0, 8'h00, 0,1,0, 0, 0, 0,0, 10'h0AA, 0);

        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        chk("rst_vld",  -1, 32'(bus.OutValid), 0);
        chk("rst_dat",  -1, 32'(bus.OutData),  0);
        chk("rst_idx",  -1, 32'(bus.OutIndex), 0);
        chk("rst_last", -1, 32'(bus.OutLast),  0);
        chk("rst_tot",  -1, 32'(bus.Total),    0);
        chk("rst_flg",  -1, 32'({bus.Overrun, bus.Incomplete, bus.AddrError}), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].rdy, vecs[i].clr, vecs[i].ordy);
            step();
            chk_outs("vec", i, vecs[i].e_vld, vecs[i].e_dat, vecs[i].e_idx,
                     vecs[i].e_last, vecs[i].e_tot, vecs[i].e_flg);
        end

        // Reset in the middle of a stream, with a sticky flag pending
        drive(1, 0, 8'h00, 0, 0, 0); step();
        drive(1, 7, 8'hA1, 0, 0, 0); step();
        drive(1, 15, 8'hB2, 0, 0, 0); step();
        drive(1, 23, 8'hC3, 0, 0, 0); step();
        drive(1, 31, 8'hD4, 0, 0, 0); step();
        drive(0, 0, 8'h00, 1, 0, 1); step();
        drive(0, 0, 8'h00, 0, 0, 1); step(); step();
        chk_outs("mid", 0, 1, 8'hC3, 2, 0, 10'h2EA, 3'b001);
        #2 Reset = 1'b1;
        #1;
        chk("ar_vld",  0, 32'(bus.OutValid), 0);
        chk("ar_dat",  0, 32'(bus.OutData),  0);
        chk("ar_idx",  0, 32'(bus.OutIndex), 0);
        chk("ar_last", 0, 32'(bus.OutLast),  0);
        chk("ar_tot",  0, 32'(bus.Total),    0);
        chk("ar_flg",  0, 32'({bus.Overrun, bus.Incomplete, bus.AddrError}), 0);
        drive(0, 0, 8'h00, 0, 0, 0);
        @(negedge Clock);
        Reset = 1'b0;

        drive(1, 7, 8'h01, 0, 0, 0); step();
        drive(1, 15, 8'h02, 0, 0, 0); step();
        drive(1, 23, 8'h03, 0, 0, 0); step();
        drive(1, 31, 8'h04, 0, 0, 0); step();
        drive(0, 0, 8'h00, 1, 0, 1); step();
        chk_outs("post", 0, 1, 8'h01, 0, 0, 10'h00A, 0);
        drive(0, 0, 8'h00, 0, 0, 1); step();
        chk_outs("post", 1, 1, 8'h02, 1, 0, 10'h00A, 0);
        drive(0, 0, 8'h00, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
